// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: state encodings,
// countdown width and the default memory latency.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam int CNT_W           = 4;
    localparam int MEM_LATENCY_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable countdown that times one memory access; zero marks the completion cycle.
// Holds at zero when not loaded, so an idle counter always reads as expired.
module lat_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data stages.
// Data wins the idle cycle; a redirected fetch still occupies the memory but never completes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    arb_state_e state_q, state_d;
    logic       cxl_q, cxl_d;
    logic       op_wr_q, op_wr_d;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       dm_req;

    assign dm_req = dm_rd | dm_wr;

    lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        cxl_d     = cxl_q;
        op_wr_d   = op_wr_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        if_rdata  = '0;
        dm_done   = 1'b0;
        dm_rdata  = '0;
        case (state_q)
            ARB_IDLE: begin
                cxl_d = 1'b0;
                if (dm_req) begin
                    // A simultaneous rd+wr is flagged on err and carried out as a write.
                    mem_en    = 1'b1;
                    mem_wr    = dm_wr;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wr ? dm_wdata : '0;
                    op_wr_d   = dm_wr;
                    cnt_load  = 1'b1;
                    state_d   = ARB_BUSY_D;
                end else if (if_req && !if_cancel) begin
                    mem_en   = 1'b1;
                    mem_addr = if_addr;
                    op_wr_d  = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                if (cnt_zero) begin
                    state_d = ARB_IDLE;
                    cxl_d   = 1'b0;
                    if (!(cxl_q || if_cancel)) begin
                        if_done  = 1'b1;
                        if_rdata = mem_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    cxl_d   = cxl_q | if_cancel;
                end
            end
            ARB_BUSY_D: begin
                if (cnt_zero) begin
                    state_d  = ARB_IDLE;
                    dm_done  = 1'b1;
                    dm_rdata = op_wr_q ? '0 : mem_rdata;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cxl_q   <= 1'b0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cxl_q   <= cxl_d;
            op_wr_q <= op_wr_d;
        end
    end

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;
    assign err      = (dm_rd & dm_wr) | (mem_en & mem_addr[0]);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 4, one at latency 1,
// sharing the same stimulus.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_cancel;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;

    logic [15:0] if_rdata_l1, dm_rdata_l1, mem_addr_l1, mem_wdata_l1;
    logic        if_done_l1, if_stall_l1, dm_done_l1, dm_stall_l1, mem_en_l1, mem_wr_l1, err_l1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(16), .DATA_W(16)) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_rdata(if_rdata_l1), .if_done(if_done_l1), .if_stall(if_stall_l1),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_l1), .dm_done(dm_done_l1), .dm_stall(dm_stall_l1),
        .mem_en(mem_en_l1), .mem_wr(mem_wr_l1), .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1),
        .mem_rdata(mem_rdata), .err(err_l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Cycles in which an access is in flight: nothing issues, nothing completes.
    task automatic busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            settle();
            chk1({tag, "_mem_en"}, mem_en, 1'b0);
            chk16({tag, "_mem_addr"}, mem_addr, 16'h0000);
            chk1({tag, "_if_done"}, if_done, 1'b0);
            chk1({tag, "_dm_done"}, dm_done, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        settle();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_dm_done", dm_done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_if_stall", if_stall, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        // Fetch only: issue t0, done t4.
        if_req = 1'b1; if_addr = 16'h0010;
        settle();
        chk1("f_t0_mem_en", mem_en, 1'b1);
        chk1("f_t0_mem_wr", mem_wr, 1'b0);
        chk16("f_t0_mem_addr", mem_addr, 16'h0010);
        chk1("f_t0_if_stall", if_stall, 1'b1);
        chk1("f_t0_err", err, 1'b0);
        tick();
        for (int i = 1; i < 4; i++) begin
            settle();
            chk1("f_wait_stall", if_stall, 1'b1);
            chk1("f_wait_mem_en", mem_en, 1'b0);
            chk16("f_wait_if_rdata", if_rdata, 16'h0000);
            chk1("f_wait_if_done", if_done, 1'b0);
            tick();
        end
        mem_rdata = 16'h1234;
        settle();
        chk1("f_t4_if_done", if_done, 1'b1);
        chk16("f_t4_if_rdata", if_rdata, 16'h1234);
        chk1("f_t4_if_stall", if_stall, 1'b0);
        chk1("f_t4_mem_en", mem_en, 1'b0);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        settle();
        chk1("f_t5_mem_en", mem_en, 1'b0);
        chk1("f_t5_if_done", if_done, 1'b0);
        tick();

        // Contention: data wins t0 (done t4), fetch issues t5 (done t9).
        if_req = 1'b1; if_addr = 16'h0020; dm_rd = 1'b1; dm_addr = 16'h0200;
        settle();
        chk1("c_t0_mem_en", mem_en, 1'b1);
        chk16("c_t0_mem_addr", mem_addr, 16'h0200);
        chk1("c_t0_mem_wr", mem_wr, 1'b0);
        chk1("c_t0_if_stall", if_stall, 1'b1);
        chk1("c_t0_dm_stall", dm_stall, 1'b1);
        tick();
        busy(3, "c_d");
        mem_rdata = 16'h5678;
        settle();
        chk1("c_t4_dm_done", dm_done, 1'b1);
        chk16("c_t4_dm_rdata", dm_rdata, 16'h5678);
        chk1("c_t4_dm_stall", dm_stall, 1'b0);
        chk1("c_t4_if_done", if_done, 1'b0);
        chk16("c_t4_if_rdata", if_rdata, 16'h0000);
        chk1("c_t4_mem_en", mem_en, 1'b0);
        tick();
        dm_rd = 1'b0; mem_rdata = '0;
        settle();
        chk1("c_t5_mem_en", mem_en, 1'b1);
        chk16("c_t5_mem_addr", mem_addr, 16'h0020);
        chk16("c_t5_dm_rdata", dm_rdata, 16'h0000);
        tick();
        busy(3, "c_i");
        mem_rdata = 16'h9ABC;
        settle();
        chk1("c_t9_if_done", if_done, 1'b1);
        chk16("c_t9_if_rdata", if_rdata, 16'h9ABC);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        tick();

        // Store.
        dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        settle();
        chk1("s_t0_mem_en", mem_en, 1'b1);
        chk1("s_t0_mem_wr", mem_wr, 1'b1);
        chk16("s_t0_mem_addr", mem_addr, 16'h0100);
        chk16("s_t0_mem_wdata", mem_wdata, 16'hBEEF);
        chk1("s_t0_err", err, 1'b0);
        tick();
        settle();
        chk16("s_t1_mem_wdata", mem_wdata, 16'h0000);
        tick();
        busy(2, "s");
        mem_rdata = 16'hFFFF;
        settle();
        chk1("s_t4_dm_done", dm_done, 1'b1);
        chk16("s_t4_dm_rdata", dm_rdata, 16'h0000);
        tick();
        dm_wr = 1'b0; dm_wdata = '0; mem_rdata = '0;
        tick();

        // Cancel: fetch t0, redirect t2, completion at t4 suppressed, new fetch t5, done t9.
        if_req = 1'b1; if_addr = 16'h0030;
        settle();
        chk1("x_t0_mem_en", mem_en, 1'b1);
        tick();
        tick();
        if_cancel = 1'b1; if_addr = 16'h0040;
        settle();
        chk1("x_t2_mem_en", mem_en, 1'b0);
        tick();
        if_cancel = 1'b0;
        tick();
        mem_rdata = 16'h1111;
        settle();
        chk1("x_t4_if_done", if_done, 1'b0);
        chk16("x_t4_if_rdata", if_rdata, 16'h0000);
        chk1("x_t4_if_stall", if_stall, 1'b1);
        chk1("x_t4_mem_en", mem_en, 1'b0);
        tick();
        mem_rdata = '0;
        settle();
        chk1("x_t5_mem_en", mem_en, 1'b1);
        chk16("x_t5_mem_addr", mem_addr, 16'h0040);
        tick();
        busy(3, "x");
        mem_rdata = 16'h2222;
        settle();
        chk1("x_t9_if_done", if_done, 1'b1);
        chk16("x_t9_if_rdata", if_rdata, 16'h2222);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        tick();

        // Errors: rd+wr together issues as write; odd fetch address flags with mem_en.
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0102; dm_wdata = 16'h00AA;
        settle();
        chk1("e_rw_err", err, 1'b1);
        chk1("e_rw_mem_en", mem_en, 1'b1);
        chk1("e_rw_mem_wr", mem_wr, 1'b1);
        chk16("e_rw_mem_wdata", mem_wdata, 16'h00AA);
        tick();
        settle();
        chk1("e_rw_t1_err", err, 1'b1);
        tick();
        busy(2, "e_rw");
        mem_rdata = 16'h7777;
        settle();
        chk1("e_rw_t4_dm_done", dm_done, 1'b1);
        chk16("e_rw_t4_dm_rdata", dm_rdata, 16'h0000);
        tick();
        dm_rd = 1'b0; dm_wr = 1'b0; dm_wdata = '0; mem_rdata = '0;
        settle();
        chk1("e_clear_err", err, 1'b0);
        tick();
        if_req = 1'b1; if_addr = 16'h0011;
        settle();
        chk1("e_odd_mem_en", mem_en, 1'b1);
        chk1("e_odd_err", err, 1'b1);
        tick();
        settle();
        chk1("e_odd_t1_err", err, 1'b0);
        tick();
        busy(2, "e_odd");
        mem_rdata = 16'h5555;
        settle();
        chk1("e_odd_t4_if_done", if_done, 1'b1);
        chk16("e_odd_t4_if_rdata", if_rdata, 16'h5555);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        tick();

        // Reset in BUSY_D with cnt=2; the late memory result must be ignored.
        dm_rd = 1'b1; dm_addr = 16'h0300;
        settle();
        chk1("r_t0_mem_en", mem_en, 1'b1);
        tick();
        tick();
        rst = 1'b1; dm_rd = 1'b0;
        settle();
        chk1("r_t2_mem_en", mem_en, 1'b0);
        chk1("r_t2_dm_done", dm_done, 1'b0);
        chk1("r_t2_dm_stall", dm_stall, 1'b0);
        tick();
        rst = 1'b0; if_req = 1'b1; if_addr = 16'h0060;
        settle();
        chk1("r_t3_mem_en", mem_en, 1'b1);
        chk16("r_t3_mem_addr", mem_addr, 16'h0060);
        tick();
        mem_rdata = 16'hDEAD;
        settle();
        chk1("r_t4_dm_done", dm_done, 1'b0);
        chk16("r_t4_dm_rdata", dm_rdata, 16'h0000);
        chk1("r_t4_if_done", if_done, 1'b0);
        tick();
        mem_rdata = '0;
        busy(2, "r");
        mem_rdata = 16'h4444;
        settle();
        chk1("r_t7_if_done", if_done, 1'b1);
        chk16("r_t7_if_rdata", if_rdata, 16'h4444);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        tick();

        // Latency 1: issue t0, done t1, reissue t2.
        if_req = 1'b1; if_addr = 16'h0050;
        settle();
        chk1("l1_t0_mem_en", mem_en_l1, 1'b1);
        chk16("l1_t0_mem_addr", mem_addr_l1, 16'h0050);
        tick();
        mem_rdata = 16'h3333;
        settle();
        chk1("l1_t1_if_done", if_done_l1, 1'b1);
        chk16("l1_t1_if_rdata", if_rdata_l1, 16'h3333);
        chk1("l1_t1_mem_en", mem_en_l1, 1'b0);
        tick();
        mem_rdata = '0; if_addr = 16'h0052;
        settle();
        chk1("l1_t2_mem_en", mem_en_l1, 1'b1);
        chk16("l1_t2_mem_addr", mem_addr_l1, 16'h0052);
        chk1("l1_t2_if_done", if_done_l1, 1'b0);
        tick();
        mem_rdata = 16'h3344;
        settle();
        chk1("l1_t3_if_done", if_done_l1, 1'b1);
        chk16("l1_t3_if_rdata", if_rdata_l1, 16'h3344);
        tick();
        if_req = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 6; i++) tick();
        settle();
        chk1("end_idle_mem_en", mem_en, 1'b0);
        chk1("end_idle_l1_mem_en", mem_en_l1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
